// File: rtl/sfifo.sv
//------------------------------------------------------------------------------
// sfifo : single-clock FIFO with registered read data and occupancy count.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sfifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic                  re,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    generate
        if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_depth_check
            $error("sfifo: DEPTH must be a power of two of at least 2");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags come purely from the registered count, so they never see we/re.
    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign wr_acc = we && !full;
    assign rd_acc = re && !empty;
    assign dout   = dout_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        dout_d  = dout_q;
        if (wr_acc) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (rd_acc) begin
            rptr_d = rptr_q + AW'(1);
            dout_d = mem_q[rptr_q];
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end
    end

    // Storage has no reset; the count guarantees stale words are never read.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sfifo.sv
//------------------------------------------------------------------------------
// tb_sfifo : directed vector-table bench for sfifo (DATA_WIDTH=8, DEPTH=16).
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sfifo;

    logic       clk;
    logic       rst_n;
    logic       we;
    logic       re;
    logic [7:0] din;
    logic [7:0] dout;
    logic       full;
    logic       empty;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       we;
        logic       re;
        logic [7:0] din;
        logic [7:0] dout;
        logic       full;
        logic       empty;
    } vec_t;

    vec_t vecs[$];

    sfifo #(
        .DATA_WIDTH(8),
        .DEPTH     (16)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (we),
        .re   (re),
        .din  (din),
        .dout (dout),
        .full (full),
        .empty(empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void add(input logic w, input logic r, input logic [7:0] d,
                                input logic [7:0] xd, input logic xf, input logic xe);
        vec_t v;
        v.we = w; v.re = r; v.din = d; v.dout = xd; v.full = xf; v.empty = xe;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [7:0] xd, input logic xf, input logic xe);
        checks++;
        if ({dout, full, empty} !== {xd, xf, xe}) begin
            errors++;
            $display("FAIL %s: got dout=%0d full=%b empty=%b, want dout=%0d full=%b empty=%b",
                     nm, dout, full, empty, xd, xf, xe);
        end
    endtask

    task automatic step(input logic w, input logic r, input logic [7:0] d);
        we = w; re = r; din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Fill, overflow attempt, drain plus underflow.
        for (int i = 1; i <= 16; i++) add(1'b1, 1'b0, 8'(i), 8'd0, (i == 16), 1'b0);
        add(1'b1, 1'b0, 8'd17, 8'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 16; i++) add(1'b0, 1'b1, 8'd0, 8'(i), 1'b0, (i == 16));
        add(1'b0, 1'b1, 8'd0, 8'd16, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'd0, 8'd16, 1'b0, 1'b1);
        // Eight stored, then 20 simultaneous edges crossing the pointer wrap.
        for (int i = 0; i < 8; i++) add(1'b1, 1'b0, 8'(101 + i), 8'd16, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) add(1'b1, 1'b1, 8'(109 + i), 8'(101 + i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) add(1'b0, 1'b1, 8'd0, 8'(121 + i), 1'b0, (i == 7));
        // Full with we=re=1: read only.
        for (int i = 0; i < 16; i++) add(1'b1, 1'b0, 8'(201 + i), 8'd128, (i == 15), 1'b0);
        add(1'b1, 1'b1, 8'd250, 8'd201, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'd0, 8'd201, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) add(1'b0, 1'b1, 8'd0, 8'(202 + i), 1'b0, (i == 14));
        add(1'b0, 1'b1, 8'd0, 8'd216, 1'b0, 1'b1);
        // Empty with we=re=1: write only, no write-through.
        add(1'b1, 1'b1, 8'd77, 8'd216, 1'b0, 1'b0);
        add(1'b0, 1'b1, 8'd0, 8'd77, 1'b0, 1'b1);

        // Reset with activity on we/re.
        rst_n = 1'b0; we = 1'b1; re = 1'b1; din = 8'hAA;
        #2;
        chk("reset_early", 8'd0, 1'b0, 1'b1);
        #24;
        chk("reset_late", 8'd0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].we, vecs[k].re, vecs[k].din);
            chk($sformatf("vec%0d", k), vecs[k].dout, vecs[k].full, vecs[k].empty);
        end

        // Mid-operation asynchronous reset between edges.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 8'(31 + i));
            chk($sformatf("pre_rst_wr%0d", i), 8'd77, 1'b0, 1'b0);
        end
        we = 1'b0; re = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_reset", 8'd0, 1'b0, 1'b1);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 8'd99);
        chk("post_rst_wr", 8'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'd0);
        chk("post_rst_rd", 8'd99, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
